// File: rtl/arb_types.sv
// Shared types and line-geometry constants for the I/D cache line arbiter.
package arb_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    CL_I = 1'b0,
    CL_D = 1'b1
  } arb_client_t;

  localparam int LINE_W = 256;

  // Byte-offset bits within one line.
  function automatic int line_ofs(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  localparam int LINE_OFS = line_ofs(LINE_W);

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client
// that was not granted last.
module arb_rr_pick
  import arb_types::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  arb_client_t last_grant,
  output logic        grant_valid,
  output arb_client_t grant_client
);

  always_comb begin
    grant_valid  = i_req | d_req;
    grant_client = CL_I;
    if (i_req && d_req) begin
      grant_client = (last_grant == CL_I) ? CL_D : CL_I;
    end else if (d_req) begin
      grant_client = CL_D;
    end
  end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares one physical_memory line port between the I-cache and D-cache,
// one whole-line transaction at a time with round-robin priority.
//
// state | meaning
// IDLE  | sampling client requests, grant on any request
// BUSY  | memory transaction outstanding, mem_* driven from request regs
// DONE  | one-cycle resp to the granted client, then back to IDLE
module cache_line_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = LINE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int OFS = line_ofs(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFS){1'b1}}, {OFS{1'b0}}};

  arb_state_t  state_q, state_d;
  arb_client_t last_grant_q;
  logic        req_read_q, req_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] line_q;

  logic        grant_valid;
  arb_client_t grant_client;

  logic                  sel_read, sel_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [LINE_WIDTH-1:0] sel_wdata;

  arb_rr_pick u_pick (
    .i_req        (i_read | i_write),
    .d_req        (d_read | d_write),
    .last_grant   (last_grant_q),
    .grant_valid  (grant_valid),
    .grant_client (grant_client)
  );

  always_comb begin
    sel_read    = i_read;
    sel_write   = i_write;
    sel_address = i_address;
    sel_wdata   = i_wdata;
    if (grant_client == CL_D) begin
      sel_read    = d_read;
      sel_write   = d_write;
      sel_address = d_address;
      sel_wdata   = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CL_I;
      req_read_q   <= 1'b0;
      req_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        // A client raising read and write together is treated as a writeback.
        req_write_q  <= sel_write;
        req_read_q   <= sel_read & ~sel_write;
        addr_q       <= sel_address & LINE_MASK;
        wdata_q      <= sel_wdata;
        last_grant_q <= grant_client;
      end
      if (state_q == BUSY && mem_resp) begin
        line_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = BUSY;
      end
      BUSY: begin
        mem_read  = req_read_q;
        mem_write = req_write_q;
        if (mem_resp) state_d = DONE;
      end
      DONE: begin
        i_resp  = (last_grant_q == CL_I);
        d_resp  = (last_grant_q == CL_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = line_q;
  assign d_rdata     = line_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed plus randomized bench for cache_line_arbiter against a
// transaction-level round-robin model with a latency-randomized memory.
module tb_cache_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, i_write, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] i_wdata, d_wdata;
  logic         i_resp, d_resp;
  logic [255:0] i_rdata, d_rdata;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  bit last_d;   // model: last granted client was D
  bit win_d;    // model: client granted in the latest round

  always #5 clk = ~clk;

  cache_line_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_req(input bit is_d);
    int op;
    logic rd, wr;
    op = $urandom_range(0, 3);
    rd = (op != 1);
    wr = (op == 1) || (op == 2);
    if (is_d) begin
      d_read = rd; d_write = wr; d_address = $urandom; d_wdata = rand_line();
    end else begin
      i_read = rd; i_write = wr; i_address = $urandom; i_wdata = rand_line();
    end
  endtask

  task automatic drop_all();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  // One arbitration round from IDLE: predicts the winner from the
  // round-robin rule, plays memory with the given latency and checks the
  // handshake. The winner then drops or re-requests; the loser keeps holding.
  task automatic round(input int lat, input bit i_again, input bit d_again);
    bit ip, dp, ewr;
    logic [31:0]  ea;
    logic [255:0] ew, rd;
    ip = i_read | i_write;
    dp = d_read | d_write;
    if (!ip && !dp) begin
      new_req(0);
      ip = 1;
    end
    win_d  = (ip && dp) ? !last_d : dp;
    ewr    = win_d ? d_write : i_write;
    ea     = (win_d ? d_address : i_address) & 32'hFFFF_FFE0;
    ew     = win_d ? d_wdata : i_wdata;
    rd     = rand_line();
    last_d = win_d;
    step();
    for (int k = 0; k < lat; k++) begin
      chk("busy_mem_read", mem_read, !ewr);
      chk("busy_mem_write", mem_write, ewr);
      chk("busy_mem_address", mem_address, ea);
      chk("busy_mem_wdata", mem_wdata, ew);
      chk("busy_i_resp", i_resp, 0);
      chk("busy_d_resp", d_resp, 0);
      if (k == lat - 1) begin
        mem_resp  = 1;
        mem_rdata = rd;
      end
      step();
    end
    mem_resp  = 0;
    mem_rdata = rand_line();
    chk("done_i_resp", i_resp, !win_d);
    chk("done_d_resp", d_resp, win_d);
    chk("done_rdata", win_d ? d_rdata : i_rdata, rd);
    chk("done_mem_read", mem_read, 0);
    chk("done_mem_write", mem_write, 0);
    if (win_d) begin
      if (d_again) new_req(1);
      else begin d_read = 0; d_write = 0; end
    end else begin
      if (i_again) new_req(0);
      else begin i_read = 0; i_write = 0; end
    end
    step();
    chk("idle_i_resp", i_resp, 0);
    chk("idle_d_resp", d_resp, 0);
    chk("idle_mem_read", mem_read, 0);
    chk("idle_mem_write", mem_write, 0);
  endtask

  initial begin
    rst = 1;
    drop_all();
    i_address = 0; d_address = 0; i_wdata = 0; d_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    last_d = 0;
    win_d = 0;
    step();
    step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 0;
    step();

    // Single I-read, latency 4, unaligned address
    i_read = 1; i_address = 32'h0000_0064; i_wdata = rand_line();
    round(4, 0, 0);
    chk("iread_was_i", win_d, 0);

    // D writeback of a constant pattern
    d_write = 1; d_address = 32'h0000_1FE0; d_wdata = {32{8'hA5}};
    round(3, 0, 0);
    chk("dwb_was_d", win_d, 1);

    // Reset in the middle of a transaction
    i_read = 1; i_address = $urandom; i_wdata = rand_line();
    step();
    chk("pre_rst_mem_read", mem_read, 1);
    step();
    rst = 1;
    #1;
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_mem_write", mem_write, 0);
    chk("midrst_mem_address", mem_address, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_i_rdata", i_rdata, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    drop_all();
    mem_resp = 1;
    step();
    mem_resp = 0;
    rst = 0;
    last_d = 0;
    for (int k = 0; k < 5; k++) begin
      chk("postrst_i_resp", i_resp, 0);
      chk("postrst_d_resp", d_resp, 0);
      chk("postrst_mem_read", mem_read, 0);
      step();
    end

    // Simultaneous requests from reset: D, I, D, I
    new_req(0);
    new_req(1);
    for (int r = 0; r < 4; r++) begin
      round($urandom_range(1, 4), 1, 1);
      chk("tie_order", win_d, (r % 2 == 0));
    end

    // Starvation: D re-requests continuously while I holds
    drop_all();
    new_req(0);
    new_req(1);
    round(2, 0, 1);
    chk("starve_first_d", win_d, 1);
    round(2, 0, 1);
    chk("starve_then_i", win_d, 0);
    round(2, 0, 0);
    chk("starve_d_again", win_d, 1);
    drop_all();

    // Spurious mem_resp while idle
    mem_resp = 1;
    step();
    mem_resp = 0;
    chk("spur_i_resp", i_resp, 0);
    chk("spur_d_resp", d_resp, 0);
    chk("spur_mem_read", mem_read, 0);
    step();
    chk("spur_i_resp2", i_resp, 0);
    chk("spur_d_resp2", d_resp, 0);

    // Read and write together from one client
    i_read = 1; i_write = 1; i_address = 32'h0000_0ABC; i_wdata = rand_line();
    round(2, 0, 0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      if (!(i_read | i_write) && $urandom_range(0, 1)) new_req(0);
      if (!(d_read | d_write) && $urandom_range(0, 1)) new_req(1);
      round($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
